// File: rtl/hazard_scoreboard.sv
// Purpose: hazard controller for the 5-stage core; tracks E/M/W register writers and selects ID-stage bypass sources.
// Latency: forward selects and stall are combinational from the current scoreboard and D inputs; the scoreboard advances one stage per clock.
// Backpressure: stall freezes PC and F/D and bubbles D/E, on data hazards (tnew > tuse) or when D needs a busy MDU.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  regA1,
  input  logic [4:0]  regA2,
  input  logic [1:0]  tuseRs,
  input  logic [1:0]  tuseRt,
  input  logic [4:0]  regA3,
  input  logic        regWrite,
  input  logic [1:0]  tnewD,
  input  logic        isMD,
  input  logic        mdStartE,
  input  logic        mdBusy,
  output logic [1:0]  regRD1Forward,
  output logic [1:0]  regRD2Forward,
  output logic        stall,
  output logic [31:0] stallCount
);

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] tnew;
    logic       vld;
  } entry_t;

  typedef struct packed {
    logic       stl;
    logic [1:0] fwd;
  } res_t;

  entry_t e_ent, m_ent, w_ent;
  res_t   rs_res, rt_res;
  logic   md_stall;

  // One source register against the pipeline; the first hit walking E->M->W is the newest writer.
  // A W hit needs no bypass: the GRF writes through in the same cycle, so it reads as FWD_GRF.
  function automatic res_t resolve(input entry_t e, input entry_t m, input entry_t w,
                                   input logic [4:0] r, input logic [1:0] tuse);
    res_t res;
    res.fwd = FWD_GRF;
    res.stl = 1'b0;
    if (r != 5'd0) begin
      if (e.vld && e.addr == r) begin
        if (e.tnew == 2'd0) res.fwd = FWD_EX;
        res.stl = (tuse != TUSE_NONE) && (e.tnew > tuse);
      end else if (m.vld && m.addr == r) begin
        if (m.tnew == 2'd0) res.fwd = FWD_MEM;
        res.stl = (tuse != TUSE_NONE) && (m.tnew > tuse);
      end else if (w.vld && w.addr == r) begin
        res.fwd = FWD_GRF;
        res.stl = 1'b0;
      end
    end
    return res;
  endfunction

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Hazard resolution for both sources plus MDU occupancy; reset forces a quiet, stall-free output.
  always_comb begin
    rs_res        = resolve(e_ent, m_ent, w_ent, regA1, tuseRs);
    rt_res        = resolve(e_ent, m_ent, w_ent, regA2, tuseRt);
    md_stall      = isMD && (mdStartE || mdBusy);
    stall         = 1'b0;
    regRD1Forward = FWD_GRF;
    regRD2Forward = FWD_GRF;
    if (!reset) begin
      stall         = rs_res.stl | rt_res.stl | md_stall;
      regRD1Forward = rs_res.fwd;
      regRD2Forward = rt_res.fwd;
    end
  end

  // Advance the writer scoreboard one stage per clock, bubbling E while stalled, and count stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_ent      <= '0;
      m_ent      <= '0;
      w_ent      <= '0;
      stallCount <= '0;
    end else begin
      if (stall) begin
        e_ent <= '0;
      end else begin
        e_ent <= '{addr: regA3, tnew: tnewD, vld: regWrite && (regA3 != 5'd0)};
      end
      m_ent <= '{addr: e_ent.addr, tnew: dec_sat(e_ent.tnew), vld: e_ent.vld};
      w_ent <= '{addr: m_ent.addr, tnew: dec_sat(m_ent.tnew), vld: m_ent.vld};
      if (stall && (stallCount != 32'hFFFF_FFFF)) begin
        stallCount <= stallCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: self-checking bench for hazard_scoreboard using an expected-result queue.
// Latency: each vector is driven just after a rising edge and checked on the following falling edge.
// Backpressure: expected stall values drive the bench's own stall-cycle count.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  regA1, regA2, regA3;
  logic [1:0]  tuseRs, tuseRt, tnewD;
  logic        regWrite, isMD, mdStartE, mdBusy;
  logic [1:0]  regRD1Forward, regRD2Forward;
  logic        stall;
  logic [31:0] stallCount;

  typedef struct {
    string       tag;
    logic        st;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] sc_model;
  int          n_vec;
  int          n_err;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .regA1(regA1), .regA2(regA2), .tuseRs(tuseRs), .tuseRt(tuseRt),
    .regA3(regA3), .regWrite(regWrite), .tnewD(tnewD),
    .isMD(isMD), .mdStartE(mdStartE), .mdBusy(mdBusy),
    .regRD1Forward(regRD1Forward), .regRD2Forward(regRD2Forward),
    .stall(stall), .stallCount(stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pop one expectation per falling edge and compare against the DUT.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check({x.tag, ".stall"}, {31'd0, stall}, {31'd0, x.st});
      check({x.tag, ".fwd1"},  {30'd0, regRD1Forward}, {30'd0, x.f1});
      check({x.tag, ".fwd2"},  {30'd0, regRD2Forward}, {30'd0, x.f2});
      check({x.tag, ".stallCount"}, stallCount, x.sc);
    end
  end

  task automatic step(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [1:0] trs, input logic [1:0] trt,
                      input logic [4:0] a3, input logic rw, input logic [1:0] tn,
                      input logic md, input logic mds, input logic mdb,
                      input logic est, input logic [1:0] ef1, input logic [1:0] ef2,
                      input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst; regA1 = a1; regA2 = a2; tuseRs = trs; tuseRt = trt;
    regA3 = a3; regWrite = rw; tnewD = tn; isMD = md; mdStartE = mds; mdBusy = mdb;
    x.tag = tag; x.st = est; x.f1 = ef1; x.f2 = ef2; x.sc = sc_model;
    exp_q.push_back(x);
    if (rst) sc_model = 32'd0;
    else if (est) sc_model = sc_model + 32'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; sc_model = 32'd0;
    reset = 1'b1; regA1 = 5'd0; regA2 = 5'd0; tuseRs = 2'd3; tuseRt = 2'd3;
    regA3 = 5'd0; regWrite = 1'b0; tnewD = 2'd0; isMD = 1'b0; mdStartE = 1'b0; mdBusy = 1'b0;

    //   rst a1  a2  trs trt a3  rw tn  md mds mdb  st f1 f2
    // Reset with a writer and reader of $5 presented: outputs forced quiet
    step(1, 5,  0,  0,  3,  5,  1, 1,  0, 0, 0,   0, 0, 0, "rst0");
    step(1, 5,  0,  0,  3,  5,  1, 1,  0, 0, 0,   0, 0, 0, "rst1");
    step(0, 5,  0,  0,  3,  0,  0, 0,  0, 0, 0,   0, 0, 0, "post_rst");
    // ALU -> beq
    step(0, 0,  0,  3,  3,  3,  1, 1,  0, 0, 0,   0, 0, 0, "addu3");
    step(0, 3,  0,  0,  0,  0,  0, 0,  0, 0, 0,   1, 0, 0, "beq_stall");
    step(0, 3,  0,  0,  0,  0,  0, 0,  0, 0, 0,   0, 2, 0, "beq_fwd_mem");
    // Load-use with ALU consumer
    step(0, 0,  0,  3,  3,  4,  1, 2,  0, 0, 0,   0, 0, 0, "lw4");
    step(0, 4,  0,  1,  3,  5,  1, 1,  0, 0, 0,   1, 0, 0, "lu_stall");
    step(0, 4,  0,  1,  3,  5,  1, 1,  0, 0, 0,   0, 0, 0, "lu_go");
    // Load-use with branch consumer: two stall cycles
    step(0, 0,  0,  3,  3,  6,  1, 2,  0, 0, 0,   0, 0, 0, "lw6");
    step(0, 6,  0,  0,  3,  0,  0, 0,  0, 0, 0,   1, 0, 0, "lb_stall0");
    step(0, 6,  0,  0,  3,  0,  0, 0,  0, 0, 0,   1, 0, 0, "lb_stall1");
    step(0, 6,  0,  0,  3,  0,  0, 0,  0, 0, 0,   0, 0, 0, "lb_go");
    // jal -> jr; rt also names $31 but is unused, select still reported
    step(0, 0,  0,  3,  3, 31,  1, 0,  0, 0, 0,   0, 0, 0, "jal");
    step(0, 31, 31, 0,  3,  0,  0, 0,  0, 0, 0,   0, 1, 1, "jr_fwd_ex");
    // Newest writer wins: E (not ready) hides M (ready)
    step(0, 0,  0,  3,  3,  2,  1, 1,  0, 0, 0,   0, 0, 0, "addu2");
    step(0, 0,  0,  3,  3,  2,  1, 1,  0, 0, 0,   0, 0, 0, "ori2");
    step(0, 2,  2,  1,  1,  0,  0, 0,  0, 0, 0,   0, 0, 0, "prio_e_over_m");
    step(0, 0,  2,  3,  0,  0,  0, 0,  0, 0, 0,   0, 0, 2, "m_fwd_rt");
    // $0 never tracked or matched
    step(0, 0,  0,  3,  3,  0,  1, 1,  0, 0, 0,   0, 0, 0, "wr_r0");
    step(0, 0,  0,  0,  0,  0,  0, 0,  0, 0, 0,   0, 0, 0, "rd_r0");
    // Hazard on rt only
    step(0, 0,  0,  3,  3,  7,  1, 1,  0, 0, 0,   0, 0, 0, "addu7");
    step(0, 0,  7,  3,  0,  0,  0, 0,  0, 0, 0,   1, 0, 0, "rt_stall");
    step(0, 0,  7,  3,  0,  0,  0, 0,  0, 0, 0,   0, 0, 2, "rt_fwd_mem");
    // MDU: start then five busy cycles hold mflo
    step(0, 0,  0,  3,  3,  0,  0, 0,  1, 0, 0,   0, 0, 0, "mult_d");
    step(0, 0,  0,  3,  3,  0,  0, 0,  1, 1, 0,   1, 0, 0, "mflo_start");
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 3, 3, 0, 0, 0, 1, 0, 1,  1, 0, 0, "mflo_busy");
    step(0, 0,  0,  3,  3,  0,  0, 0,  1, 0, 0,   0, 0, 0, "mflo_go");
    step(0, 0,  0,  3,  3,  0,  0, 0,  0, 1, 0,   0, 0, 0, "nonmd_start");
    step(0, 0,  0,  3,  3,  0,  0, 0,  0, 0, 1,   0, 0, 0, "nonmd_busy");
    // Reset mid-run forces outputs and clears the scoreboard
    step(0, 0,  0,  3,  3,  8,  1, 2,  0, 0, 0,   0, 0, 0, "lw8");
    step(1, 8,  8,  0,  0,  0,  0, 0,  0, 0, 0,   0, 0, 0, "rst_force_stall");
    step(0, 8,  8,  0,  0,  0,  0, 0,  0, 0, 0,   0, 0, 0, "rst_clear");
    step(0, 0,  0,  3,  3, 31,  1, 0,  0, 0, 0,   0, 0, 0, "jal2");
    step(1, 31, 31, 0,  0,  0,  0, 0,  0, 0, 0,   0, 0, 0, "rst_force_fwd");
    step(0, 31, 31, 0,  0,  0,  0, 0,  0, 0, 0,   0, 0, 0, "rst_clear_fwd");

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
